uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one uart_tx (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16: watchdog limit for uart_busy to assert after issue.
REQ-003 The block SHALL have port clk  input  1: single clock, also the uart_tx clock.
REQ-004 The block SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  NUM_REQ: per-requester byte pending.
REQ-006 The block SHALL have port req_data  input  8*NUM_REQ: byte i at bits [8i+7:8i].
REQ-007 The block SHALL have port req_ready  output  NUM_REQ: one-cycle accept pulse per requester.
REQ-008 The block SHALL have port uart_data  output  8: byte to uart_tx data.
REQ-009 The block SHALL have port uart_data_valid  output  1: one-cycle start pulse to uart_tx data_valid.
REQ-010 The block SHALL have port uart_busy  input  1: uart_tx tx_busy.
REQ-011 The block SHALL have port grant_id  output  clog2(NUM_REQ): index of the last accepted requester.
REQ-012 The block SHALL have port active  output  1: high whenever state is not IDLE.
REQ-013 The block SHALL have port timeout_err  output  1: one-cycle watchdog pulse.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-015 In IDLE with uart_busy=0 and any req_valid high at edge t, the block SHALL select the winner round-robin, register its byte, and at t+1 drive uart_data=byte, uart_data_valid=1, req_ready[winner]=1 and grant_id=winner, then enter WAIT_BUSY.
REQ-016 uart_data_valid and req_ready SHALL each be high for exactly one cycle per accepted byte; uart_data SHALL hold its value until the next accept.
REQ-017 Round-robin SHALL search from pointer p upward modulo NUM_REQ; after granting i, p SHALL become (i+1) mod NUM_REQ.
REQ-018 In IDLE with uart_busy=1, the block SHALL NOT issue.
REQ-019 In WAIT_BUSY, uart_busy=1 SHALL move the FSM to WAIT_DONE.
REQ-020 In WAIT_DONE, uart_busy=0 SHALL move the FSM to IDLE; the earliest next accept SHALL be sampled on the following edge.
REQ-021 Requesters SHALL hold req_valid and req_data stable until req_ready; deasserting req_valid before acceptance SHALL be legal and SHALL withdraw the request with no side effect.
REQ-022 req_valid changes outside IDLE SHALL be ignored until return to IDLE.

Reset
REQ-023 When rst is asserted, the block SHALL asynchronously force state=IDLE, p=0, uart_data=0, uart_data_valid=0, req_ready=0, grant_id=0, active=0, timeout_err=0, and timeout counter=0.
REQ-024 Reset mid-transfer SHALL abandon the byte with no replay; the first request after deassertion SHALL be arbitrated from p=0.

Configuration
REQ-025 With UART_TX_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_BUSY; on reaching TIMEOUT_CYCLES without uart_busy, the block SHALL pulse timeout_err for one cycle and return to IDLE, keeping p as already advanced.
REQ-026 Without UART_TX_ARB_TIMEOUT_EN, the block SHALL remain in WAIT_BUSY indefinitely, timeout_err SHALL be tied to 0, and no counter SHALL be synthesized.

Structure
REQ-027 Shared package uart_pkg SHALL hold UART_DATA_W=8 and the arbiter state enum type.
REQ-028 Round-robin selection (req vector and pointer in; one-hot grant and index out) SHALL be the combinational sub-module rr_arbiter.

Verification
REQ-029 Bench SHALL check: req_valid[0]=1, req_data byte0=0x55 -> uart_data=0x55, one-cycle uart_data_valid and req_ready[0], grant_id=0, and no further issue until busy rises then falls.
REQ-030 Bench SHALL check: all four requesters valid from reset with bytes 0xA0..0xA3 -> uart_data sequence A0, A1, A2, A3, then A0 if req_valid[0] is still high.
REQ-031 Bench SHALL check: requesters 1 and 2 continuously valid -> grants alternate 1, 2, 1, 2.
REQ-032 Bench SHALL check: uart_busy=1 in IDLE with req_valid[3]=1 -> no issue until busy=0, then byte 3 is issued next cycle.
REQ-033 Bench SHALL check: rst pulsed during WAIT_DONE -> all outputs 0 immediately; the next requests {1,3} grant 1 first.
REQ-034 Bench SHALL check: with TIMEOUT_EN defined and uart_busy stuck at 0 -> timeout_err pulses 16 cycles after issue and the next request is served; without the macro, active stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: data width and FSM state type.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping
// modulo NUM_REQ. Returns a one-hot grant and the matching index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic found;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!found && req[(int'(ptr) + off) % NUM_REQ]) begin
        found                                 = 1'b1;
        grant[(int'(ptr) + off) % NUM_REQ]    = 1'b1;
        grant_idx                             = IDX_W'((int'(ptr) + off) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte requesters using round-robin arbitration.
// Optional busy watchdog is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [UART_DATA_W-1:0]           uart_data,
  output logic                             uart_data_valid,
  input  logic                             uart_busy,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             active,
  output logic                             timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       win_idx;
  logic [NUM_REQ-1:0]     win_onehot;
  logic [UART_DATA_W-1:0] win_byte;
  logic                   issue;
  logic                   timeout_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (win_onehot),
    .grant_idx (win_idx)
  );

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) win_byte = req_data[i*UART_DATA_W +: UART_DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Requests are only looked at in IDLE; changes elsewhere are ignored.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!uart_busy && |req_valid) begin
          issue   = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (uart_busy)        state_d = WAIT_DONE;
        else if (timeout_hit) state_d = IDLE;
      end
      WAIT_DONE: begin
        if (!uart_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active = (state_q != IDLE);
  end

  // Accept datapath: byte and grant hold until the next accept; strobes are one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q           <= '0;
      uart_data       <= '0;
      uart_data_valid <= 1'b0;
      req_ready       <= '0;
      grant_id        <= '0;
    end else begin
      uart_data_valid <= issue;
      req_ready       <= issue ? win_onehot : '0;
      if (issue) begin
        uart_data <= win_byte;
        grant_id  <= win_idx;
        ptr_q     <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // Counter value k means k cycles spent in WAIT_BUSY without busy.
  assign timeout_hit = (state_q == WAIT_BUSY) && !uart_busy &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if ((state_q == WAIT_BUSY) && !uart_busy && !timeout_hit) cnt_q <= cnt_q + CNT_W'(1);
      else                                                       cnt_q <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
